// File: rtl/recovery_rom_arbiter.sv
`timescale 1ns/1ps
// recovery_rom_arbiter
//   Shares the single-port recovery code ROM between NUM_REQ instruction-fetch
//   requesters. Arbitration is round-robin. Each granted address is checked
//   against the ROM window and for word alignment. An address outside the
//   window never reaches the ROM and gets an error response. Every grant gets
//   exactly one response one cycle later, so responses come back in grant order.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous reset, active-high
//   req_i        fetch request, one bit per requester
//   addr_i       byte address, 32 bits per requester (requester k at [32k +: 32])
//   gnt_o        combinational grant, one-hot or zero
//   rvalid_o     response valid, one-hot or zero
//   err_o        response error, qualified by rvalid_o
//   rdata_o      response data, shared by all requesters (zero when no data)
//   rom_req_o    ROM read strobe
//   rom_addr_o   byte offset into the ROM (addr - BASE_ADDR)
//   rom_rdata_i  ROM read data, valid the cycle after rom_req_o
module recovery_rom_arbiter #(
    parameter int          NUM_REQ   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_8000,
    parameter int          ROM_SIZE  = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [NUM_REQ*32-1:0] addr_i,
    output logic [NUM_REQ-1:0]   gnt_o,
    output logic [NUM_REQ-1:0]   rvalid_o,
    output logic [NUM_REQ-1:0]   err_o,
    output logic [31:0]          rdata_o,
    output logic                 rom_req_o,
    output logic [31:0]          rom_addr_o,
    input  logic [31:0]          rom_rdata_i
);

    localparam int              IDX_W     = $clog2(NUM_REQ);
    localparam logic [IDX_W:0]  NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [32:0]     ROM_BYTES = 33'(4 * ROM_SIZE);

    logic [IDX_W-1:0] rr_q;
    logic [IDX_W-1:0] resp_id_q;
    logic             resp_valid_q;
    logic             resp_err_q;

    logic [IDX_W:0]   cand_sum;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_found;
    logic             grant_live;
    logic [31:0]      gnt_addr;
    logic [32:0]      gnt_off;
    logic             gnt_legal;

    // ---- Request stage: round-robin pick starting at rr_q ----
    always_comb begin
        cand_sum  = '0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // rr_q and i are both below NUM_REQ, so a single subtract wraps the sum.
            cand_sum = {1'b0, rr_q} + (IDX_W+1)'(i);
            if (cand_sum >= NUM_REQ_W) begin
                cand_sum = cand_sum - NUM_REQ_W;
            end
            if (!gnt_found && req_i[cand_sum[IDX_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand_sum[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        gnt_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == IDX_W'(i)) begin
                gnt_addr = addr_i[i*32 +: 32];
            end
        end
    end

    // The subtraction is done in 33 bits. An address below BASE_ADDR borrows
    // into bit 32, so the offset becomes larger than any window size and the
    // single unsigned compare rejects both ends of the window.
    assign gnt_off    = {1'b0, gnt_addr} - {1'b0, BASE_ADDR};
    assign gnt_legal  = (gnt_off < ROM_BYTES) && (gnt_addr[1:0] == 2'b00);
    assign grant_live = gnt_found && !rst_i;

    always_comb begin
        gnt_o = '0;
        if (grant_live) begin
            gnt_o[gnt_idx] = 1'b1;
        end
    end

    assign rom_req_o  = grant_live && gnt_legal;
    assign rom_addr_o = rom_req_o ? gnt_off[31:0] : 32'h0;

    // ---- Response stage: one cycle after the grant, aligned with ROM data ----
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= gnt_found;
            if (gnt_found) begin
                rr_q       <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
                resp_id_q  <= gnt_idx;
                resp_err_q <= !gnt_legal;
            end
        end
    end

    always_comb begin
        rvalid_o = '0;
        err_o    = '0;
        if (resp_valid_q) begin
            rvalid_o[resp_id_q] = 1'b1;
            err_o[resp_id_q]    = resp_err_q;
        end
    end

    assign rdata_o = (resp_valid_q && !resp_err_q) ? rom_rdata_i : 32'h0;

endmodule
